pressure_monitor: RTL and testbench

//   Sequential, parametrised successor to the 5-bit combinational pressure check.

---
 rtl/pressure_pkg.sv | 20 ++
 rtl/pressure_classifier.sv | 30 +++
 rtl/pressure_monitor.sv | 181 ++++++++++++++++++
 tb/tb_pressure_monitor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pressure_pkg.sv
// Shared definitions for the pressure monitor.
//   state_e      : monitor FSM states (NORMAL, ARMING, WARN, RELEASING)
//   DEF_*        : default sample width, thresholds, persistence and counter width
package pressure_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'd0,
    ST_ARMING    = 2'd1,
    ST_WARN      = 2'd2,
    ST_RELEASING = 2'd3
  } state_e;

  localparam int DEF_WIDTH   = 5;
  localparam int DEF_LOW_TH  = 7;
  localparam int DEF_HIGH_TH = 23;
  localparam int DEF_HYST    = 1;
  localparam int DEF_PERSIST = 3;
  localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/pressure_classifier.sv
// Combinational classification of one pressure sample.
//   pData  in  : unsigned sample
//   oor    out : sample at or below LOW_TH, or at or above HIGH_TH
//   is_low out : sample at or below LOW_TH (meaningful when oor)
//   safe   out : sample strictly inside (LOW_TH+HYST, HIGH_TH-HYST)
// Samples that are neither oor nor safe form the hysteresis hold zone.
module pressure_classifier #(
  parameter int WIDTH   = 5,
  parameter int LOW_TH  = 7,
  parameter int HIGH_TH = 23,
  parameter int HYST    = 1
) (
  input  logic [WIDTH-1:0] pData,
  output logic             oor,
  output logic             is_low,
  output logic             safe
);

  localparam logic [WIDTH-1:0] LOW_V       = WIDTH'(LOW_TH);
  localparam logic [WIDTH-1:0] HIGH_V      = WIDTH'(HIGH_TH);
  localparam logic [WIDTH-1:0] SAFE_LO_EXC = WIDTH'(LOW_TH + HYST);
  localparam logic [WIDTH-1:0] SAFE_HI_EXC = WIDTH'(HIGH_TH - HYST);

  always_comb begin
    is_low = (pData <= LOW_V);
    oor    = is_low || (pData >= HIGH_V);
    safe   = (pData > SAFE_LO_EXC) && (pData < SAFE_HI_EXC);
  end

endmodule

// File: rtl/pressure_monitor.sv
// Debounced pressure warning with hysteresis.
//   clk, rstN             : clock, asynchronous active-low reset
//   pData, pValid         : pressure sample and its qualifier
//   alarmAck              : clears the sticky alarm
//   pWarning              : debounced warning (WARN or RELEASING)
//   warnLow, warnHigh     : direction of the latest out-of-range sample while warning
//   pAlarm                : sticky, set on every fresh warning entry
//   warnCount             : saturating count of fresh warning entries
//   dbg_state             : current FSM state, for observation only
// Sample handshake: a sample is consumed on a rising clk edge where pValid=1;
// pValid=0 cycles change nothing except alarm acknowledgement.
module pressure_monitor
  import pressure_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LOW_TH  = DEF_LOW_TH,
  parameter int HIGH_TH = DEF_HIGH_TH,
  parameter int HYST    = DEF_HYST,
  parameter int PERSIST = DEF_PERSIST,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [WIDTH-1:0] pData,
  input  logic             pValid,
  input  logic             alarmAck,
  output logic             pWarning,
  output logic             warnLow,
  output logic             warnHigh,
  output logic             pAlarm,
  output logic [CNT_W-1:0] warnCount,
  output state_e           dbg_state
);

  localparam int CW = $clog2(PERSIST + 1);

  if (PERSIST < 1 || (LOW_TH + HYST) >= (HIGH_TH - HYST - 1) || HIGH_TH >= (2 ** WIDTH))
  begin : g_param_check
    $error("pressure_monitor: inconsistent parameters");
  end

  logic oor, is_low, safe;

  pressure_classifier #(
    .WIDTH  (WIDTH),
    .LOW_TH (LOW_TH),
    .HIGH_TH(HIGH_TH),
    .HYST   (HYST)
  ) u_classifier (
    .pData (pData),
    .oor   (oor),
    .is_low(is_low),
    .safe  (safe)
  );

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              warning_q, warning_d;
  logic              low_q, low_d;
  logic              high_q, high_d;
  logic              alarm_q, alarm_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CW-1:0]     cnt_inc;
  logic              enter;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    low_d   = low_q;
    high_d  = high_q;
    enter   = 1'b0;
    cnt_inc = cnt_q + CW'(1);

    if (pValid) begin
      case (state_q)
        ST_NORMAL: begin
          if (oor) begin
            if (PERSIST == 1) enter = 1'b1;
            else begin
              state_d = ST_ARMING;
              cnt_d   = CW'(1);
            end
          end
        end
        ST_ARMING: begin
          if (oor) begin
            if (cnt_inc == CW'(PERSIST)) enter = 1'b1;
            else cnt_d = cnt_inc;
          end else begin
            state_d = ST_NORMAL;
            cnt_d   = '0;
          end
        end
        ST_WARN: begin
          if (safe) begin
            if (PERSIST == 1) begin
              state_d = ST_NORMAL;
              cnt_d   = '0;
            end else begin
              state_d = ST_RELEASING;
              cnt_d   = CW'(1);
            end
          end else if (oor) begin
            low_d  = is_low;
            high_d = ~is_low;
          end
        end
        ST_RELEASING: begin
          if (safe) begin
            if (cnt_inc == CW'(PERSIST)) begin
              state_d = ST_NORMAL;
              cnt_d   = '0;
            end else cnt_d = cnt_inc;
          end else begin
            // A break in the safe run falls back to WARN; this is not a fresh entry.
            state_d = ST_WARN;
            cnt_d   = '0;
            if (oor) begin
              low_d  = is_low;
              high_d = ~is_low;
            end
          end
        end
        default: begin
          state_d = ST_NORMAL;
          cnt_d   = '0;
        end
      endcase

      if (enter) begin
        state_d = ST_WARN;
        cnt_d   = '0;
        low_d   = is_low;
        high_d  = ~is_low;
      end
    end

    if (state_d == ST_NORMAL) begin
      low_d  = 1'b0;
      high_d = 1'b0;
    end

    warning_d = (state_d == ST_WARN) || (state_d == ST_RELEASING);

    // Entry and acknowledge on the same edge leaves the alarm set.
    if (enter)         alarm_d = 1'b1;
    else if (alarmAck) alarm_d = 1'b0;
    else               alarm_d = alarm_q;

    count_d = count_q;
    if (enter && (count_q != {CNT_W{1'b1}})) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= ST_NORMAL;
      cnt_q     <= '0;
      warning_q <= 1'b0;
      low_q     <= 1'b0;
      high_q    <= 1'b0;
      alarm_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      warning_q <= warning_d;
      low_q     <= low_d;
      high_q    <= high_d;
      alarm_q   <= alarm_d;
      count_q   <= count_d;
    end
  end

  assign pWarning  = warning_q;
  assign warnLow   = low_q;
  assign warnHigh  = high_q;
  assign pAlarm    = alarm_q;
  assign warnCount = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pressure_monitor.sv
// Bench for pressure_monitor: directed sequences followed by random samples,
// compared against a run-length reference model after every clock edge.
// A second instance with a 2-bit event counter shares all inputs so that
// counter saturation is exercised alongside the default configuration.
module tb_pressure_monitor;
  import pressure_pkg::*;

  localparam int WIDTH   = 5;
  localparam int LOW_TH  = 7;
  localparam int HIGH_TH = 23;
  localparam int HYST    = 1;
  localparam int PERSIST = 3;
  localparam int MAX1    = 255;
  localparam int MAX2    = 3;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic [WIDTH-1:0] pData = '0;
  logic             pValid = 1'b1;
  logic             alarmAck = 1'b0;

  logic       pWarning, warnLow, warnHigh, pAlarm;
  logic [7:0] warnCount;
  state_e     dbg_state;
  logic       pWarning2, warnLow2, warnHigh2, pAlarm2;
  logic [1:0] warnCount2;
  state_e     dbg_state2;

  always #5 clk = ~clk;

  pressure_monitor u_dut (
    .clk(clk), .rstN(rstN), .pData(pData), .pValid(pValid), .alarmAck(alarmAck),
    .pWarning(pWarning), .warnLow(warnLow), .warnHigh(warnHigh), .pAlarm(pAlarm),
    .warnCount(warnCount), .dbg_state(dbg_state)
  );

  pressure_monitor #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rstN(rstN), .pData(pData), .pValid(pValid), .alarmAck(alarmAck),
    .pWarning(pWarning2), .warnLow(warnLow2), .warnHigh(warnHigh2), .pAlarm(pAlarm2),
    .warnCount(warnCount2), .dbg_state(dbg_state2)
  );

  // Reference model: consecutive-run lengths and a warning flag.
  int m_warn, m_low, m_high, m_alarm, m_cnt1, m_cnt2, oor_run, safe_run;
  int n_vec = 0;
  int n_err = 0;

  task automatic model_reset();
    m_warn = 0; m_low = 0; m_high = 0; m_alarm = 0;
    m_cnt1 = 0; m_cnt2 = 0; oor_run = 0; safe_run = 0;
  endtask

  task automatic model_step(input int d, input int v, input int ack);
    bit is_oor, is_safe, entry;
    is_oor  = (d <= LOW_TH) || (d >= HIGH_TH);
    is_safe = (d > LOW_TH + HYST) && (d < HIGH_TH - HYST);
    entry   = 0;
    if (v != 0) begin
      if (m_warn == 0) begin
        oor_run = is_oor ? oor_run + 1 : 0;
        if (oor_run == PERSIST) begin
          m_warn = 1; entry = 1; oor_run = 0; safe_run = 0;
        end
      end else begin
        safe_run = is_safe ? safe_run + 1 : 0;
        if (safe_run == PERSIST) begin
          m_warn = 0; safe_run = 0; oor_run = 0;
        end
      end
      if (m_warn != 0 && is_oor) begin
        m_low  = (d <= LOW_TH) ? 1 : 0;
        m_high = 1 - m_low;
      end
    end
    if (m_warn == 0) begin m_low = 0; m_high = 0; end
    if (entry) begin
      m_alarm = 1;
      if (m_cnt1 < MAX1) m_cnt1++;
      if (m_cnt2 < MAX2) m_cnt2++;
    end else if (ack != 0) m_alarm = 0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input int exp);
    n_vec++;
    assert (obs === 8'(exp)) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pWarning"},   {7'd0, pWarning},   m_warn);
    chk({tag, ".warnLow"},    {7'd0, warnLow},    m_low);
    chk({tag, ".warnHigh"},   {7'd0, warnHigh},   m_high);
    chk({tag, ".pAlarm"},     {7'd0, pAlarm},     m_alarm);
    chk({tag, ".warnCount"},  warnCount,          m_cnt1);
    chk({tag, ".warnCount2"}, {6'd0, warnCount2}, m_cnt2);
  endtask

  // Drive one cycle's inputs, clock it, then compare shortly after the edge.
  task automatic step(input string tag, input int d, input int v, input int ack);
    pData    = WIDTH'(d);
    pValid   = (v != 0);
    alarmAck = (ack != 0);
    @(posedge clk);
    model_step(d, v, ack);
    #1;
    check_all(tag);
  endtask

  initial begin
    int d, r;
    model_reset();

    // Reset held with a valid out-of-range-ish sample present.
    rstN = 1'b0; pData = '0; pValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_all("reset");
    end
    rstN = 1'b1;

    // Three low samples with a gap between the 2nd and 3rd.
    step("low1", 5, 1, 0);
    step("low2", 5, 1, 0);
    step("gap",  5, 0, 0);
    step("low3", 5, 1, 0);
    chk("enter_warn", {7'd0, pWarning}, 1);

    // Hold-zone samples keep the warning.
    step("hold8",  8,  1, 0);
    step("hold22", 22, 1, 0);
    step("hold8b", 8,  1, 0);
    // Three safe samples release it.
    step("rel1", 10, 1, 0);
    step("rel2", 10, 1, 0);
    step("rel3", 10, 1, 0);
    chk("released", {7'd0, pWarning}, 0);

    // High entry, ack, then a broken release run.
    step("hi1", 30, 1, 0);
    step("hi2", 30, 1, 0);
    step("hi3", 30, 1, 0);
    step("ack", 30, 0, 1);
    step("br1", 10, 1, 0);
    step("br2", 10, 1, 0);
    step("br3", 30, 1, 0);
    step("br4", 10, 1, 0);
    chk("reentry_high", {7'd0, warnHigh}, 1);
    step("r1", 10, 1, 0);
    step("r2", 10, 1, 0);

    // A safe sample breaks an arming run.
    step("a1", 25, 1, 0);
    step("a2", 25, 1, 0);
    step("a3", 15, 1, 0);
    step("a4", 25, 1, 0);
    step("a5", 25, 1, 0);
    chk("no_trigger", {7'd0, pWarning}, 0);
    // Entry and ack on the same edge: set wins; next ack clears.
    step("entry_ack", 25, 1, 1);
    chk("set_wins", {7'd0, pAlarm}, 1);
    step("ack2", 0, 0, 1);
    for (int i = 0; i < 3; i++) step("rel", 12, 1, 0);

    // Reset in the middle of an arming run discards it.
    step("mr1", 2, 1, 0);
    step("mr2", 2, 1, 0);
    @(negedge clk);
    rstN = 1'b0;
    model_reset();
    #1;
    check_all("midreset");
    @(posedge clk); #1;
    check_all("midreset_hold");
    @(negedge clk);
    rstN = 1'b1;
    step("after_reset", 2, 1, 0);

    // Random samples biased towards runs of out-of-range and safe values.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      d = ($urandom_range(0, 1) == 0) ? $urandom_range(0, LOW_TH) : $urandom_range(HIGH_TH, 31);
      else if (r < 9) d = $urandom_range(LOW_TH + HYST + 1, HIGH_TH - HYST - 1);
      else            d = ($urandom_range(0, 1) == 0) ? LOW_TH + HYST : HIGH_TH - HYST;
      step("rand", d, ($urandom_range(0, 9) < 8) ? 1 : 0, ($urandom_range(0, 9) == 0) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
